quad_decoder_array: RTL and testbench

QUAD_DECODER_ARRAY -- requirements
Module: quad_decoder_array

---
 rtl/qdec_pkg.sv | 30 +++
 rtl/qdec_channel.sv | 129 ++++++++++++
 rtl/quad_decoder_array.sv | 40 ++++
 tb/tb_quad_decoder_array.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and the quadrature transition decoder for the quad decoder array.
package qdec_pkg;

  typedef logic [1:0] phase_t;  // {A,B}

  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_CW      = 2'd1,
    TR_CCW     = 2'd2,
    TR_ILLEGAL = 2'd3
  } trans_t;

  // Clockwise successor: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t cw_next(input phase_t p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic trans_t decode(input phase_t prev, input phase_t curr);
    if (prev == curr)               return TR_NONE;
    else if (cw_next(prev) == curr) return TR_CW;
    else if (cw_next(curr) == prev) return TR_CCW;
    else                            return TR_ILLEGAL;
  endfunction

endpackage

// File: rtl/qdec_channel.sv
// One encoder channel: 2-flop synchroniser, optional debouncer, transition
// decoder and up/down counter. The debouncer is built only when the macro
// QDEC_DEBOUNCE_EN is defined; otherwise the synchroniser output is used as
// the filtered phase directly.
module qdec_channel
  import qdec_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 4,
  parameter int X4      = 0,
  parameter int SAT     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_t     sync1, sync2, filt, filt_d;
  logic [3:0] vld;  // prime pipeline: [2] filter may run, [3] decoder may count
  trans_t     tr;
  logic       inc, dec;

  // Synchronise raw phases; vld fills with ones so the prime waits for real samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      vld   <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      vld   <= {vld[2:0], 1'b1};
    end
  end

`ifdef QDEC_DEBOUNCE_EN
  localparam logic [7:0] DEB_RLD = 8'(DEB_CYC - 1);

  phase_t     sync_d;
  logic [7:0] deb_cnt, deb_left;

  // A fresh change restarts the down-counter; the cycle it appears counts as stable cycle one.
  assign deb_left = (sync2 != sync_d) ? DEB_RLD : deb_cnt;

  // Debounce: accept sync2 once it has differed from filt and held for DEB_CYC cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt    <= '0;
      sync_d  <= '0;
      deb_cnt <= DEB_RLD;
    end else begin
      sync_d <= sync2;
      if (!vld[2] || sync2 == filt) begin
        if (!vld[2]) filt <= sync2;
        deb_cnt <= DEB_RLD;
      end else if (deb_left == 8'd0) begin
        filt    <= sync2;
        deb_cnt <= DEB_RLD;
      end else begin
        deb_cnt <= deb_left - 8'd1;
      end
    end
  end
`else
  assign filt = sync2;

  // DEB_CYC has no effect without the debouncer.
  logic unused_deb_cyc;
  assign unused_deb_cyc = |8'(DEB_CYC);
`endif

  assign tr = decode(filt_d, filt);

  // Select which transitions count: every one in x4 mode, only those landing on 00 otherwise
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (X4 != 0) begin
      inc = (tr == TR_CW);
      dec = (tr == TR_CCW);
    end else begin
      inc = (tr == TR_CW)  && (filt == 2'b00);
      dec = (tr == TR_CCW) && (filt == 2'b00);
    end
  end

  // Counter, step/dir/err registers; clr wins over any same-cycle event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_d <= '0;
      count  <= '0;
      step   <= 1'b0;
      dir    <= 1'b0;
      err    <= 1'b0;
    end else begin
      filt_d <= filt;
      step   <= 1'b0;
      if (clr) begin
        count <= '0;
        err   <= 1'b0;
      end else if (vld[3]) begin
        if (tr == TR_ILLEGAL) begin
          err <= 1'b1;
        end else if (inc) begin
          if (SAT == 0 || count != CNT_MAX) begin
            count <= count + CNT_W'(1);
            step  <= 1'b1;
            dir   <= 1'b1;
          end
        end else if (dec) begin
          if (SAT == 0 || count != '0) begin
            count <= count - CNT_W'(1);
            step  <= 1'b1;
            dir   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/quad_decoder_array.sv
// Array of NCH independent quadrature decoder channels. Debouncing is enabled
// by defining the macro QDEC_DEBOUNCE_EN.
module quad_decoder_array #(
  parameter int NCH     = 3,
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 4,
  parameter int X4      = 0,
  parameter int SAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       enc_a,
  input  logic [NCH-1:0]       enc_b,
  input  logic [NCH-1:0]       clr,
  output logic [NCH*CNT_W-1:0] count,
  output logic [NCH-1:0]       step,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    qdec_channel #(
      .CNT_W  (CNT_W),
      .DEB_CYC(DEB_CYC),
      .X4     (X4),
      .SAT    (SAT)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (enc_a[i]),
      .b    (enc_b[i]),
      .clr  (clr[i]),
      .count(count[i*CNT_W +: CNT_W]),
      .step (step[i]),
      .dir  (dir[i]),
      .err  (err[i])
    );
  end

endmodule

// File: tb/tb_quad_decoder_array.sv
// Self-checking bench: two decoder arrays (x4/wrapping and x1/saturating),
// expected step events queued when a phase is driven, checked as steps appear.
module tb_quad_decoder_array;

  localparam int HOLD = 12;
`ifdef QDEC_DEBOUNCE_EN
  localparam int LAT    = 7;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 3;
  localparam bit DEB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  a4, b4, clr4, step4, dir4, err4;
  logic [23:0] count4;
  logic [0:0]  a1, b1, clr1, step1, dir1, err1;
  logic [7:0]  count1;

  always #5 clk = ~clk;

  quad_decoder_array #(.NCH(3), .CNT_W(8), .DEB_CYC(4), .X4(1), .SAT(0)) u_x4 (
    .clk(clk), .rst_n(rst_n), .enc_a(a4), .enc_b(b4), .clr(clr4),
    .count(count4), .step(step4), .dir(dir4), .err(err4)
  );

  quad_decoder_array #(.NCH(1), .CNT_W(8), .DEB_CYC(4), .X4(0), .SAT(1)) u_x1 (
    .clk(clk), .rst_n(rst_n), .enc_a(a1), .enc_b(b1), .clr(clr1),
    .count(count1), .step(step1), .dir(dir1), .err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int nstep4[3] = '{0, 0, 0};
  int nstep1 = 0;
  logic [10:0] q4[$];  // {ch, dir, count}
  logic [8:0]  q1[$];  // {dir, count}
  int          m4[3];
  logic [1:0]  ph4[3];
  int          m1;
  logic [1:0]  ph1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cw_of(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // x4, wrapping, 8-bit: every legal transition counts
  task automatic go4(input int ch, input logic [1:0] nxt);
    logic [1:0] cur;
    cur = ph4[ch];
    if (cw_of(cur) == nxt) begin
      m4[ch] = (m4[ch] + 1) % 256;
      q4.push_back({2'(ch), 1'b1, 8'(m4[ch])});
    end else if (cw_of(nxt) == cur) begin
      m4[ch] = (m4[ch] + 255) % 256;
      q4.push_back({2'(ch), 1'b0, 8'(m4[ch])});
    end
    ph4[ch] = nxt;
    a4[ch]  = nxt[1];
    b4[ch]  = nxt[0];
    repeat (HOLD) @(negedge clk);
  endtask

  // x1, saturating: only 10->00 (+1) and 01->00 (-1) count
  task automatic go1(input logic [1:0] nxt);
    if (ph1 == 2'b10 && nxt == 2'b00 && m1 < 255) begin
      m1++;
      q1.push_back({1'b1, 8'(m1)});
    end else if (ph1 == 2'b01 && nxt == 2'b00 && m1 > 0) begin
      m1--;
      q1.push_back({1'b0, 8'(m1)});
    end
    ph1   = nxt;
    a1[0] = nxt[1];
    b1[0] = nxt[0];
    repeat (HOLD) @(negedge clk);
  endtask

  // Scoreboard: every step pulse must match the next queued expectation
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (step4[i] === 1'b1) begin
        nstep4[i]++;
        n_cmp++;
        assert (q4.size() != 0) else begin
          n_bad++;
          $error("FAIL step4_unexpected: ch %0d observed step with count %0d, expected no step", i, count4[i*8 +: 8]);
        end
        if (q4.size() != 0) check("step4_event", {2'(i), dir4[i], count4[i*8 +: 8]}, q4.pop_front());
      end
    end
    if (step1[0] === 1'b1) begin
      nstep1++;
      n_cmp++;
      assert (q1.size() != 0) else begin
        n_bad++;
        $error("FAIL step1_unexpected: observed step with count %0d, expected no step", count1);
      end
      if (q1.size() != 0) check("step1_event", {dir1[0], count1}, q1.pop_front());
    end
  end

  initial begin
    int s;
    rst_n = 1'b0;
    a4 = '0; b4 = '0; clr4 = '0;
    a1 = '0; b1 = '0; clr1 = '0;
    for (int i = 0; i < 3; i++) begin m4[i] = 0; ph4[i] = 2'b00; end
    m1 = 0; ph1 = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_count4", count4, 0);
    check("rst_err4", err4, 0);
    check("rst_dir4", dir4, 0);
    check("rst_step4", step4, 0);
    check("rst_count1", count1, 0);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check("prime_err4", err4, 0);

    // four full CW cycles on channel 0, x4
    s = nstep4[0];
    repeat (4) begin go4(0, 2'b01); go4(0, 2'b11); go4(0, 2'b10); go4(0, 2'b00); end
    check("x4_count0", count4[7:0], 16);
    check("x4_dir0", dir4[0], 1);
    check("x4_steps0", nstep4[0] - s, 16);
    check("x4_others", count4[23:8], 0);

    // x1 saturating: up to 2, then three CCW detents
    repeat (2) begin go1(2'b01); go1(2'b11); go1(2'b10); go1(2'b00); end
    check("x1_count_up", count1, 2);
    s = nstep1;
    repeat (3) begin go1(2'b10); go1(2'b11); go1(2'b01); go1(2'b00); end
    check("x1_sat_count", count1, 0);
    check("x1_sat_steps", nstep1 - s, 2);
    check("x1_sat_dir", dir1, 0);

    // wrap on channel 1: 0 -> 255 -> 0
    s = nstep4[1];
    go4(1, 2'b10);
    check("wrap_dn_count", count4[15:8], 255);
    check("wrap_dn_dir", dir4[1], 0);
    go4(1, 2'b00);
    check("wrap_up_count", count4[15:8], 0);
    check("wrap_up_dir", dir4[1], 1);
    check("wrap_steps", nstep4[1] - s, 2);

    // 2-cycle glitch on A of channel 2
    s = nstep4[2];
    if (!DEB_ON) begin
      q4.push_back({2'd2, 1'b0, 8'd255});
      q4.push_back({2'd2, 1'b1, 8'd0});
    end
    a4[2] = 1'b1;
    repeat (2) @(negedge clk);
    a4[2] = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("glitch_steps", nstep4[2] - s, DEB_ON ? 0 : 2);
    check("glitch_count", count4[23:16], 0);

    // illegal 00 -> 11 jump, then a CW step, clr, and clr over a CW step
    s = nstep4[2];
    go4(2, 2'b11);
    check("illegal_err", err4[2], 1);
    check("illegal_count", count4[23:16], 0);
    check("illegal_steps", nstep4[2] - s, 0);
    go4(2, 2'b10);
    check("post_illegal_count", count4[23:16], 1);
    check("err_sticky", err4[2], 1);
    clr4[2] = 1'b1;
    @(negedge clk);
    clr4[2] = 1'b0;
    m4[2] = 0;
    @(negedge clk);
    check("clr_count", count4[23:16], 0);
    check("clr_err", err4[2], 0);
    s = nstep4[2];
    clr4[2] = 1'b1;
    ph4[2] = 2'b00; a4[2] = 1'b0; b4[2] = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    clr4[2] = 1'b0;
    repeat (HOLD) @(negedge clk);
    check("clr_coinc_count", count4[23:16], 0);
    check("clr_coinc_steps", nstep4[2] - s, 0);
    check("q4_empty_pre_rst", q4.size(), 0);
    check("q1_empty_pre_rst", q1.size(), 0);

    // reset pulse mid-debounce with channel 0 inputs at 11
    a4[0] = 1'b1; b4[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) m4[i] = 0;
    ph4[0] = 2'b11;
    m1 = 0;
    check("rst2_count4", count4, 0);
    check("rst2_dir4", dir4, 0);
    check("rst2_err4", err4, 0);
    check("rst2_step4", step4, 0);
    repeat (HOLD) @(negedge clk);
    check("rst2_prime_err4", err4, 0);
    check("rst2_prime_count4", count4, 0);
    go4(0, 2'b10);
    go4(0, 2'b00);
    check("rst2_count0", count4[7:0], 2);
    check("rst2_dir0", dir4[0], 1);

    check("q4_empty", q4.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
